// File: rtl/led_pwm_fade_wb.sv
// led_pwm_fade_wb: Wishbone soft LED PWM controller, N_CH channels with linear fade toward target duty.
// Duty changes are applied only at the period boundary through a per-channel shadow register.
module led_pwm_fade_wb #(
   parameter int N_CH       = 3,
   parameter int PWM_W      = 8,
   parameter int PRESCALE_W = 16
) (
   input  logic              clk,
   input  logic              rst,
   output logic [N_CH-1:0]   pwm_out,
   input  logic [4:0]        wb_addr,
   output logic [31:0]       wb_rdata,
   input  logic [31:0]       wb_wdata,
   input  logic              wb_we,
   input  logic              wb_cyc,
   output logic              wb_ack
);
   localparam logic [PWM_W-1:0] CNT_LAST = PWM_W'((1 << PWM_W) - 2);

   logic                  en;
   logic                  fade_en;
   logic [PRESCALE_W-1:0] prescale;
   logic [PRESCALE_W-1:0] pre_cnt;
   logic [PWM_W-1:0]      cnt;
   logic [PWM_W-1:0]      target [N_CH];
   logic [PWM_W-1:0]      cur    [N_CH];
   logic [PWM_W-1:0]      shadow [N_CH];
   logic [N_CH-1:0]       status;
   logic                  access;
   logic                  wr;
   logic                  tick;
   logic [31:0]           rd;
   logic                  unused_wdata;

   assign access       = wb_cyc & ~wb_ack;
   assign wr           = access & wb_we;
   assign tick         = en & (pre_cnt == '0);
   assign unused_wdata = ^wb_wdata;

   always_comb begin
      status = '0;
      for (int i = 0; i < N_CH; i++)
         status[i] = cur[i] != target[i];
   end

   always_comb begin
      rd = '0;
      if (wb_addr == 5'd0)
         rd = {30'd0, fade_en, en};
      else if (wb_addr == 5'd1)
         rd = 32'(prescale);
      else if (wb_addr == 5'd2)
         rd = 32'(status);
      for (int i = 0; i < N_CH; i++) begin
         if (wb_addr == 5'(8 + i))
            rd = 32'(target[i]);
         if (wb_addr == 5'(16 + i))
            rd = 32'(cur[i]);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wb_ack   <= 1'b0;
         wb_rdata <= '0;
         en       <= 1'b0;
         fade_en  <= 1'b0;
         prescale <= '0;
      end else begin
         wb_ack   <= access;
         wb_rdata <= access ? rd : '0;
         if (wr && wb_addr == 5'd0)
            {fade_en, en} <= wb_wdata[1:0];
         if (wr && wb_addr == 5'd1)
            prescale <= wb_wdata[PRESCALE_W-1:0];
      end
   end

   // Shared period counter and fade prescaler; both parked at 0 while disabled.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt     <= '0;
         pre_cnt <= '0;
      end else if (!en) begin
         cnt     <= '0;
         pre_cnt <= '0;
      end else begin
         cnt     <= (cnt == CNT_LAST) ? '0 : cnt + PWM_W'(1);
         pre_cnt <= tick ? prescale : pre_cnt - PRESCALE_W'(1);
      end
   end

   // At cnt=0 the comparator uses CUR directly, the same value the shadow captures for the rest of the period.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pwm_out <= '0;
         for (int i = 0; i < N_CH; i++) begin
            target[i] <= '0;
            cur[i]    <= '0;
            shadow[i] <= '0;
         end
      end else begin
         for (int i = 0; i < N_CH; i++) begin
            if (wr && wb_addr == 5'(8 + i))
               target[i] <= wb_wdata[PWM_W-1:0];
            if (!fade_en)
               cur[i] <= target[i];
            else if (tick && cur[i] != target[i])
               cur[i] <= (cur[i] < target[i]) ? cur[i] + PWM_W'(1) : cur[i] - PWM_W'(1);
            if (en && cnt == '0)
               shadow[i] <= cur[i];
            pwm_out[i] <= en & (cnt < ((cnt == '0) ? cur[i] : shadow[i]));
         end
      end
   end
endmodule

// File: tb/tb_led_pwm_fade_wb.sv
// tb_led_pwm_fade_wb: directed register vectors plus hand-timed PWM, fade, enable and reset sequences.
module tb_led_pwm_fade_wb;
   localparam int N_CH = 3;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic [N_CH-1:0] pwm_out;
   logic [4:0]      wb_addr = '0;
   logic [31:0]     wb_rdata;
   logic [31:0]     wb_wdata = '0;
   logic            wb_we = 1'b0;
   logic            wb_cyc = 1'b0;
   logic            wb_ack;

   int total = 0;
   int bad = 0;

   typedef struct packed {
      logic [4:0]  addr;
      logic        we;
      logic [31:0] wdata;
      logic [31:0] exp;
   } vec_t;
   vec_t vecs[$];

   logic mon_on = 1'b0;
   logic mon_prev = 1'b0;
   logic mon_started = 1'b0;
   int   mon_len = 0;
   int   hi_q[$];
   int   lo_q[$];

   led_pwm_fade_wb #(.N_CH(N_CH), .PWM_W(8), .PRESCALE_W(16)) dut (
      .clk(clk), .rst(rst), .pwm_out(pwm_out), .wb_addr(wb_addr), .wb_rdata(wb_rdata),
      .wb_wdata(wb_wdata), .wb_we(wb_we), .wb_cyc(wb_cyc), .wb_ack(wb_ack)
   );

   always #5 clk = ~clk;

   // Run-length recorder for channel 1, first run starts at the first transition after enabling.
   always @(negedge clk) begin
      if (mon_on) begin
         if (pwm_out[1] != mon_prev) begin
            if (mon_started) begin
               if (mon_prev) hi_q.push_back(mon_len);
               else lo_q.push_back(mon_len);
            end
            mon_started = 1'b1;
            mon_len = 1;
         end else
            mon_len++;
      end
      mon_prev = pwm_out[1];
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic bus(input logic [4:0] a, input logic [31:0] d, input logic we, output logic [31:0] r);
      int n = 0;
      @(posedge clk);
      #1;
      wb_cyc = 1'b1; wb_we = we; wb_addr = a; wb_wdata = d;
      do begin
         step();
         n++;
      end while (!wb_ack && n < 8);
      r = wb_rdata;
      check("ack_latency", n, 1);
      wb_cyc = 1'b0; wb_we = 1'b0;
      step();
      check("ack_single", wb_ack, 0);
      check("rdata_idle", wb_rdata, 0);
   endtask

   task automatic wr(input logic [4:0] a, input logic [31:0] d);
      logic [31:0] r;
      bus(a, d, 1'b1, r);
   endtask

   task automatic rd_chk(input string name, input logic [4:0] a, input logic [31:0] e);
      logic [31:0] r;
      bus(a, 32'd0, 1'b0, r);
      check(name, r, e);
   endtask

   task automatic do_reset();
      rst = 1'b1; wb_cyc = 1'b0; wb_we = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   task automatic v(input logic [4:0] a, input logic we, input logic [31:0] d, input logic [31:0] e);
      vecs.push_back({a, we, d, e});
   endtask

   task automatic measure(input int ch, output int hi, output int lo);
      int n = 0;
      hi = 0; lo = 0;
      while (pwm_out[ch] && n < 600) begin step(); n++; end
      while (!pwm_out[ch] && n < 600) begin step(); n++; end
      while (pwm_out[ch] && n < 600) begin hi++; step(); n++; end
      while (!pwm_out[ch] && n < 600) begin lo++; step(); n++; end
      if (n >= 600) hi = -1;
   endtask

   task automatic count_high(input int ch, input int cycles, output int hi);
      hi = 0;
      repeat (cycles) begin
         step();
         hi += int'(pwm_out[ch]);
      end
   endtask

   initial begin
      int hi, lo, n;
      logic [4:0]  up_a [6] = '{5'd18, 5'd18, 5'd2, 5'd18, 5'd18, 5'd18};
      logic [31:0] up_e [6] = '{32'd1, 32'd2, 32'd4, 32'd3, 32'd4, 32'd5};
      logic [31:0] dn_e [5] = '{32'd2, 32'd1, 32'd1, 32'd0, 32'd0};

      do_reset();
      check("rst_pwm", 32'(pwm_out), 0);
      check("rst_ack", 32'(wb_ack), 0);
      check("rst_rdata", wb_rdata, 0);

      v(5'd0, 0, 0, 0); v(5'd1, 0, 0, 0); v(5'd2, 0, 0, 0); v(5'd8, 0, 0, 0); v(5'd16, 0, 0, 0);
      v(5'd1, 1, 32'h12345, 0); v(5'd1, 0, 0, 32'h2345);
      v(5'd0, 1, 32'hFFFFFFFC, 0); v(5'd0, 0, 0, 0);
      v(5'd0, 1, 32'h2, 0); v(5'd0, 0, 0, 32'h2); v(5'd0, 1, 0, 0); v(5'd0, 0, 0, 0);
      v(5'd11, 1, 32'h55, 0); v(5'd11, 0, 0, 0);
      v(5'd31, 1, 32'hFF, 0); v(5'd31, 0, 0, 0);
      v(5'd10, 1, 32'h1AB, 0); v(5'd10, 0, 0, 32'hAB); v(5'd18, 0, 0, 32'hAB); v(5'd2, 0, 0, 0);
      v(5'd18, 1, 0, 0); v(5'd18, 0, 0, 32'hAB);
      v(5'd2, 1, 32'hFF, 0); v(5'd2, 0, 0, 0);
      v(5'd9, 1, 32'h7F, 0); v(5'd9, 0, 0, 32'h7F); v(5'd17, 0, 0, 32'h7F);
      v(5'd19, 1, 32'h5, 0); v(5'd19, 0, 0, 0); v(5'd3, 0, 0, 0);
      for (int k = 0; k < vecs.size(); k++) begin
         if (vecs[k].we) wr(vecs[k].addr, vecs[k].wdata);
         else rd_chk($sformatf("vec%0d_addr%0d", k, vecs[k].addr), vecs[k].addr, vecs[k].exp);
      end

      do_reset();
      wr(5'd8, 64);
      wr(5'd0, 1);
      check("pwm_first_period", 32'(pwm_out[0]), 1);
      measure(0, hi, lo);
      check("duty64_high", hi, 64);
      check("duty64_low", lo, 191);
      check("idle_channels", 32'(pwm_out[2:1]), 0);
      wr(5'd8, 0);
      repeat (300) step();
      count_high(0, 255, hi);
      check("duty0_const_low", hi, 0);
      wr(5'd8, 255);
      repeat (300) step();
      count_high(0, 255, hi);
      check("duty255_const_high", hi, 255);

      wr(5'd9, 200);
      repeat (300) step();
      n = 0;
      while (pwm_out[1] && n < 600) begin step(); n++; end
      step(); step();
      mon_on = 1'b1;
      while (!pwm_out[1] && n < 600) begin step(); n++; end
      check("mid_sync", 32'(n < 600), 1);
      repeat (47) @(posedge clk);
      wr(5'd9, 10);
      repeat (700) step();
      check("mid_runs", 32'(hi_q.size() >= 2 && lo_q.size() >= 2), 1);
      check("mid_old_high", hi_q[0], 200);
      check("mid_old_low", lo_q[0], 55);
      check("mid_new_high", hi_q[1], 10);
      check("mid_new_low", lo_q[1], 245);
      mon_on = 1'b0;

      do_reset();
      wr(5'd0, 2); wr(5'd1, 3); wr(5'd10, 5);
      rd_chk("cur_no_tick_when_off", 5'd18, 0);
      wr(5'd0, 3);
      for (int k = 0; k < 6; k++) rd_chk($sformatf("fade_up%0d", k), up_a[k], up_e[k]);
      rd_chk("status_clear", 5'd2, 0);
      repeat (20) step();
      rd_chk("fade_hold", 5'd18, 5);

      do_reset();
      wr(5'd0, 2); wr(5'd1, 3); wr(5'd10, 5); wr(5'd0, 3);
      rd_chk("rev_pre0", 5'd18, 1);
      rd_chk("rev_pre1", 5'd18, 2);
      rd_chk("rev_pre2", 5'd18, 2);
      wr(5'd10, 0);
      for (int k = 0; k < 5; k++) rd_chk($sformatf("fade_down%0d", k), 5'd18, dn_e[k]);
      wr(5'd10, 200);
      rd_chk("snap_pre0", 5'd18, 0);
      rd_chk("snap_pre1", 5'd18, 1);
      wr(5'd0, 1);
      rd_chk("snap_to_target", 5'd18, 200);
      rd_chk("snap_status", 5'd2, 0);

      do_reset();
      wr(5'd0, 2); wr(5'd1, 3); wr(5'd10, 5); wr(5'd0, 3);
      rd_chk("frz_pre0", 5'd18, 1);
      rd_chk("frz_pre1", 5'd18, 2);
      wr(5'd0, 2);
      repeat (30) step();
      rd_chk("frz_hold", 5'd18, 3);
      rd_chk("frz_ctrl", 5'd0, 2);
      wr(5'd0, 0);
      wr(5'd8, 255);
      wr(5'd0, 1);
      check("en_pwm_on", 32'(pwm_out[0]), 1);
      repeat (10) step();
      check("en_pwm_still_on", 32'(pwm_out[0]), 1);
      wr(5'd0, 0);
      check("en_off_pwm", 32'(pwm_out), 0);
      rd_chk("en_off_cur0", 5'd16, 255);

      wr(5'd0, 1); wr(5'd0, 3); wr(5'd10, 0);
      check("pre_rst_pwm", 32'(pwm_out[0]), 1);
      @(posedge clk);
      #1;
      wb_cyc = 1'b1; wb_we = 1'b0; wb_addr = 5'd16;
      #2 rst = 1'b1;
      #1;
      check("async_rst_pwm", 32'(pwm_out), 0);
      check("async_rst_ack", 32'(wb_ack), 0);
      check("async_rst_rdata", wb_rdata, 0);
      @(posedge clk);
      #1;
      check("rst_no_ack", 32'(wb_ack), 0);
      wb_cyc = 1'b0;
      @(posedge clk);
      #1 rst = 1'b0;
      rd_chk("post_rst_cur0", 5'd16, 0);
      rd_chk("post_rst_cur2", 5'd18, 0);
      rd_chk("post_rst_ctrl", 5'd0, 0);
      rd_chk("post_rst_target0", 5'd8, 0);
      check("post_rst_pwm", 32'(pwm_out), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/led_pwm_fade_wb.md
Name: led_pwm_fade_wb

Overview:
- Wishbone-attached soft LED PWM controller with N_CH independent channels and per-channel linear fade ("breathing") toward a programmed target duty.
- Pure fabric logic with no hard macros. Outputs drive SB_RGBA_DRV PWM inputs or plain GPIO.
- Next-generation replacement for the fixed 3-channel hard-IP LED wrapper.
- Adds:
  - configurable channel count and PWM resolution;
  - glitch-free duty update at period boundary;
  - programmable fade rate;
  - readback of all registers.

Parameters:
- N_CH, 3, number of PWM channels (1..8).
- PWM_W, 8, duty/counter width in bits (4..12).
- PRESCALE_W, 16, width of fade-tick prescaler.

Ports:
- clk  in  1  system clock
- rst  in  1  reset; asynchronous, active-high
- pwm_out  out  N_CH  PWM outputs, bit i = channel i
- wb_addr  in  5  word address
- wb_rdata  out  32  read data
- wb_wdata  in  32  write data
- wb_we  in  1  write enable
- wb_cyc  in  1  cycle/strobe
- wb_ack  out  1  acknowledge

Behaviour:
- Clock and reset: one clock, clk. rst is asynchronous, active-high. On reset all registers, counters, wb_ack, wb_rdata and pwm_out are 0.
- Register map (word addresses):
  - 0 CTRL RW: bit0 EN, bit1 FADE_EN; other bits read 0.
  - 1 PRESCALE RW [PRESCALE_W-1:0].
  - 2 STATUS RO: bit i = channel i fading (cur != target).
  - 8+i TARGET[i] RW [PWM_W-1:0].
  - 16+i CUR[i] RO [PWM_W-1:0], the duty currently applied.
  - Unmapped addresses and i >= N_CH: writes ignored, reads 0. Writes to RO registers are ignored. Unused upper rdata bits read 0.
- Bus handshake:
  - wb_ack <= wb_cyc & ~wb_ack, so ack asserts exactly 1 cycle after cyc rises and is single-cycle. Back-to-back transactions take 2 cycles each.
  - A write takes effect on the cycle ack is asserted (register updated at the same edge that raises ack). Each access commits once.
  - wb_rdata is registered, valid while wb_ack=1, and 0 otherwise.
- PWM counter:
  - Shared PWM_W-bit counter counts 0..2^PWM_W-2, then wraps to 0. Period = 2^PWM_W-1 cycles.
  - pwm_out[i] is registered: 1 when cnt < applied duty. Duty 0 = constant low; duty 2^PWM_W-1 = constant high.
  - Applied duty = CUR[i] sampled into a shadow register when cnt wraps to 0. Mid-period changes never glitch the current period.
- Fade tick: a prescaler down-counter reloads from PRESCALE when it reaches 0, emitting a 1-cycle tick. PRESCALE=0 gives a tick every cycle. A PRESCALE write takes effect at the next reload.
- CUR update:
  - FADE_EN=0: CUR[i] <= TARGET[i] every cycle, so it follows within 1 cycle.
  - FADE_EN=1, on a tick: CUR moves by exactly 1 toward TARGET. If CUR == TARGET it holds. No overshoot and no wrap-around at 0 or max.
- TARGET rewritten during a fade: the fade redirects from the present CUR value with no jump.
- EN=0:
  - pwm_out forced to 0 on the next edge.
  - PWM counter and prescaler held at 0; no ticks, so CUR is frozen while FADE_EN=1.
  - Registers stay writable.
  - On EN 0->1, counting restarts from 0, with the shadow loaded at that first cnt=0.
- FADE_EN toggled 1->0 mid-fade: CUR snaps to TARGET on the next cycle.
- Reset asserted mid-fade or mid-transaction: immediate return to the reset state. No ack is issued for the interrupted cycle.

Test Plan:
- Reset, then read addrs 0,1,2,8,16 -> all 0; pwm_out=0; each ack is exactly one cycle wide, 1 cycle after cyc.
- PWM_W=8: write TARGET[0]=64, CTRL=1 -> CUR[0]=64 next cycle; pwm_out[0] high 64 of every 255 cycles, first full period starting at cnt=0. TARGET=0 -> constant low; TARGET=255 -> constant high.
- Mid-period TARGET[1] change from 200 to 10 at cnt=50 -> current period still 200 high; next period 10 high; no extra edges.
- CTRL=3, PRESCALE=3, TARGET[2]=5 from CUR 0 -> CUR increments every 4 cycles, reaching 5 after 20 cycles; STATUS bit2 clears at that point; CUR stays at 5.
- At CUR=3 in a rising fade, write TARGET=0 -> CUR 3,2,1,0, one step per tick, then stops. Clearing FADE_EN mid-fade -> CUR equals TARGET 1 cycle later.
- Write/read addr 8+N_CH and addr 31 -> acked, read 0. Clear EN -> pwm_out 0 next cycle and CUR frozen during fade. Assert rst mid-fade -> all outputs 0 asynchronously.
